// File: rtl/sid_cmd_sequencer_pkg.sv
// ============================================================================
// sid_cmd_sequencer_pkg : shared command codes, word layout and FSM states
// Revision : 1.0
// ============================================================================
`default_nettype none

package sid_cmd_sequencer_pkg;

  localparam int         c_CMD_W          = 13;
  localparam logic [4:0] c_DELAY_CMD      = 5'h1f;
  localparam logic [4:0] c_LONG_DELAY_CMD = 5'h1e;

  typedef struct packed {
    logic [4:0] addr;
    logic [7:0] data;
  } sid_cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_WAIT  = 2'd2
  } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/sid_cmd_fifo.sv
// ============================================================================
// sid_cmd_fifo : show-ahead synchronous FIFO of 13-bit SID command words
// Revision : 1.0
// ============================================================================
`default_nettype none

module sid_cmd_fifo
  import sid_cmd_sequencer_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [c_CMD_W-1:0]       wr_data,
  input  logic                     pop,
  output logic [c_CMD_W-1:0]       rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int               c_AW    = $clog2(DEPTH);
  localparam logic [c_AW:0]    c_DEPTH = (c_AW+1)'(DEPTH);

  logic [c_CMD_W-1:0] r_mem [DEPTH];
  logic [c_AW-1:0]    r_wr_ptr;
  logic [c_AW-1:0]    r_rd_ptr;
  logic [c_AW:0]      r_count;
  logic               w_do_push;
  logic               w_do_pop;

  assign full      = (r_count == c_DEPTH);
  assign empty     = (r_count == '0);
  assign level     = r_count;
  assign rd_data   = r_mem[r_rd_ptr];
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + c_AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_AW'(1);
      if (w_do_push && !w_do_pop)      r_count <= r_count + (c_AW+1)'(1);
      else if (w_do_pop && !w_do_push) r_count <= r_count - (c_AW+1)'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/sid_cmd_sequencer.sv
// ============================================================================
// sid_cmd_sequencer : buffers SID command words and replays them as sid8580
// register writes / idle delays in step with ce_1m.
// Optional macro SID_CMD_LONG_WAIT_EN : 5'h1e becomes a data*256 long wait.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sid_cmd_sequencer
  import sid_cmd_sequencer_pkg::*;
#(
  parameter int         FIFO_DEPTH = 16,
  parameter logic [4:0] DELAY_CMD  = c_DELAY_CMD
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ce_1m,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [4:0]                   cmd_addr,
  input  logic [7:0]                   cmd_data,
  output logic                         sid_we,
  output logic [4:0]                   sid_addr,
  output logic [7:0]                   sid_data,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
  output logic                         busy
);

`ifdef SID_CMD_LONG_WAIT_EN
  localparam int c_CNT_W = 16;
`else
  localparam int c_CNT_W = 8;
`endif

  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  sid_cmd_t           w_head;
  seq_state_t         r_state;
  logic [c_CNT_W-1:0] r_wait_cnt;
  logic               r_sid_we;
  logic [4:0]         r_sid_addr;
  logic [7:0]         r_sid_data;

  assign cmd_ready = !w_full;
  assign w_push    = cmd_valid && !w_full;
  assign w_pop     = ce_1m && (r_state != ST_WAIT) && !w_empty;

  sid_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (w_push),
    .wr_data ({cmd_addr, cmd_data}),
    .pop     (w_pop),
    .rd_data (w_head),
    .full    (w_full),
    .empty   (w_empty),
    .level   (fifo_level)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_wait_cnt <= '0;
      r_sid_we   <= 1'b0;
      r_sid_addr <= '0;
      r_sid_data <= '0;
    end else if (ce_1m) begin
      case (r_state)
        ST_IDLE, ST_WRITE: begin
          if (w_empty) begin
            r_sid_we <= 1'b0;
            r_state  <= ST_IDLE;
          end else if (w_head.addr == DELAY_CMD) begin
            r_sid_we <= 1'b0;
            if (w_head.data == 8'd0) begin
              r_state <= ST_IDLE;
            end else begin
              r_wait_cnt <= c_CNT_W'(w_head.data);
              r_state    <= ST_WAIT;
            end
`ifdef SID_CMD_LONG_WAIT_EN
          end else if (w_head.addr == c_LONG_DELAY_CMD) begin
            r_sid_we <= 1'b0;
            if (w_head.data == 8'd0) begin
              r_state <= ST_IDLE;
            end else begin
              r_wait_cnt <= {w_head.data, 8'h00};
              r_state    <= ST_WAIT;
            end
`endif
          end else begin
            r_sid_we   <= 1'b1;
            r_sid_addr <= w_head.addr;
            r_sid_data <= w_head.data;
            r_state    <= ST_WRITE;
          end
        end
        // The last idle pulse returns to IDLE so the next pulse can dispatch.
        ST_WAIT: begin
          if (r_wait_cnt > c_CNT_W'(1)) begin
            r_wait_cnt <= r_wait_cnt - c_CNT_W'(1);
          end else begin
            r_wait_cnt <= '0;
            r_state    <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign sid_we   = r_sid_we;
  assign sid_addr = r_sid_addr;
  assign sid_data = r_sid_data;
  assign busy     = !w_empty || (r_state != ST_IDLE) || r_sid_we;

endmodule

`default_nettype wire

// File: tb/tb_sid_cmd_sequencer.sv
// ============================================================================
// tb_sid_cmd_sequencer : directed + randomized stimulus against a queue-based
// reference of the command sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_sid_cmd_sequencer;

  localparam int c_DEPTH = 16;
  localparam int c_LW    = $clog2(c_DEPTH) + 1;

  logic            clk = 1'b0;
  logic            reset;
  logic            ce_1m;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [4:0]      cmd_addr;
  logic [7:0]      cmd_data;
  logic            sid_we;
  logic [4:0]      sid_addr;
  logic [7:0]      sid_data;
  logic [c_LW-1:0] fifo_level;
  logic            busy;

  always #5 clk = ~clk;

  sid_cmd_sequencer #(
    .FIFO_DEPTH (c_DEPTH),
    .DELAY_CMD  (5'h1f)
  ) u_dut (
    .clk        (clk),
    .reset      (reset),
    .ce_1m      (ce_1m),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_addr   (cmd_addr),
    .cmd_data   (cmd_data),
    .sid_we     (sid_we),
    .sid_addr   (sid_addr),
    .sid_data   (sid_data),
    .fifo_level (fifo_level),
    .busy       (busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  // Reference: a queue of pending words plus a count of SID pulses still to idle.
  logic [12:0] m_q[$];
  int          m_idle;
  logic        m_we;
  logic [4:0]  m_addr;
  logic [7:0]  m_data;
  int          ce_period;
  int          ce_phase;
  bit          ce_hold;

  function automatic void model_reset();
    m_q.delete();
    m_idle = 0;
    m_we   = 1'b0;
    m_addr = '0;
    m_data = '0;
  endfunction

  function automatic void model_edge();
    bit          room;
    logic [12:0] head;
    room = (m_q.size() < c_DEPTH);
    if (ce_1m) begin
      if (m_idle > 0) begin
        m_idle--;
        m_we = 1'b0;
      end else if (m_q.size() == 0) begin
        m_we = 1'b0;
      end else begin
        head = m_q.pop_front();
        if (head[12:8] == 5'h1f) begin
          m_we   = 1'b0;
          m_idle = int'(head[7:0]);
`ifdef SID_CMD_LONG_WAIT_EN
        end else if (head[12:8] == 5'h1e) begin
          m_we   = 1'b0;
          m_idle = int'(head[7:0]) * 256;
`endif
        end else begin
          m_we   = 1'b1;
          m_addr = head[12:8];
          m_data = head[7:0];
        end
      end
    end
    if (cmd_valid && room) m_q.push_back({cmd_addr, cmd_data});
  endfunction

  task automatic check_all();
    check("sid_we",     32'(sid_we),     32'(m_we));
    check("sid_addr",   32'(sid_addr),   32'(m_addr));
    check("sid_data",   32'(sid_data),   32'(m_data));
    check("cmd_ready",  32'(cmd_ready),  32'(m_q.size() < c_DEPTH));
    check("fifo_level", 32'(fifo_level), 32'(m_q.size()));
    check("busy",       32'(busy),       32'((m_q.size() > 0) || (m_idle > 0) || m_we));
  endtask

  // Called at a negedge: drive inputs, take one edge, update model, check.
  task automatic tick(input logic v, input logic [4:0] a, input logic [7:0] d);
    cmd_valid = v;
    cmd_addr  = a;
    cmd_data  = d;
    if (ce_hold) begin
      ce_1m = 1'b0;
    end else begin
      ce_1m    = (ce_phase == 0);
      ce_phase = (ce_phase + 1) % ce_period;
    end
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 5'd0, 8'd0);
  endtask

  task automatic push_word(input logic [4:0] a, input logic [7:0] d);
    int  tries;
    bit  done;
    tries = 0;
    done  = 0;
    while (!done && tries < 200) begin
      done = (m_q.size() < c_DEPTH);
      tick(1'b1, a, d);
      tries++;
    end
    if (!done) check("push_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    reset     = 1'b1;
    ce_1m     = 1'b0;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_data  = '0;
    ce_period = 12;
    ce_phase  = 0;
    ce_hold   = 0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all();
    reset = 1'b0;

    // Two back-to-back writes
    push_word(5'h04, 8'h21);
    push_word(5'h05, 8'h09);
    idle(48);
    // Delay of 3 then a write
    push_word(5'h1f, 8'd3);
    push_word(5'h18, 8'h0f);
    idle(72);
    // No-op delay then a write
    push_word(5'h1f, 8'd0);
    push_word(5'h01, 8'haa);
    idle(48);

    // Fill with ce held off: 17th word must be refused
    ce_hold = 1;
    for (int i = 0; i < 17; i++) tick(1'b1, 5'(i), 8'(8'h30 + i));
    check("full_level", 32'(fifo_level), 32'(c_DEPTH));
    check("full_ready", 32'(cmd_ready), 32'd0);
    ce_hold  = 0;
    ce_phase = 0;
    idle(12 * 18);

    // Reset while writing with words still queued
    for (int i = 0; i < 6; i++) push_word(5'(i + 2), 8'(8'h80 + i));
    begin
      int guard;
      guard = 0;
      while (!(m_we && m_q.size() >= 5) && guard < 100) begin
        idle(1);
        guard++;
      end
      check("reset_setup", 32'(m_we && m_q.size() >= 5), 32'd1);
    end
    #2 reset = 1'b1;
    #1;
    check("rst_we",    32'(sid_we),     32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_busy",  32'(busy),       32'd0);
    check("rst_ready", 32'(cmd_ready),  32'd1);
    model_reset();
    @(negedge clk);
    reset    = 1'b0;
    ce_phase = 0;
    idle(40);

    // 5'h1e: long wait with the macro, plain write without it
    push_word(5'h1e, 8'd2);
    push_word(5'h00, 8'h55);
`ifdef SID_CMD_LONG_WAIT_EN
    idle(12 * 515);
`else
    idle(48);
`endif

    // Randomized traffic with varying ce spacing
    for (int blk = 0; blk < 15; blk++) begin
      ce_period = (blk % 5 == 4) ? 40 : int'($urandom_range(3, 12));
      ce_phase  = 0;
      for (int i = 0; i < 200; i++) begin
        logic [4:0] a;
        logic [7:0] d;
        a = 5'($urandom_range(0, 31));
        d = 8'($urandom);
        if (a == 5'h1f) d = 8'($urandom_range(0, 4));
        if (a == 5'h1e) d = 8'($urandom_range(0, 1));
        tick(1'($urandom_range(0, 1)), a, d);
      end
    end
    ce_period = 12;
    ce_phase  = 0;
    idle(12 * 600);
    check("drained", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
